// File: rtl/mem_pkg.sv
// Shared store-path definitions: func3 encodings, size-to-strobe helper and the
// FIFO entry layout (sized for the widest supported configuration).
package mem_pkg;
   localparam int XLEN_MAX = 64;
   localparam int ADDR_MAX = 64;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;
   localparam logic [2:0] F3_SD = 3'b011;

   typedef struct packed {
      logic [ADDR_MAX-1:0]   addr;
      logic [XLEN_MAX/8-1:0] wstrb;
      logic [XLEN_MAX-1:0]   wdata;
   } entry_t;

   function automatic logic [7:0] size_mask(input logic [2:0] func3);
      case (func3)
         F3_SB:   size_mask = 8'h01;
         F3_SH:   size_mask = 8'h03;
         F3_SW:   size_mask = 8'h0F;
         F3_SD:   size_mask = 8'hFF;
         default: size_mask = 8'h00;
      endcase
   endfunction
endpackage

// File: rtl/store_align.sv
// Combinational lane alignment of a store: byte strobes, shifted data and
// misalignment / illegal-width detection.
module store_align
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [$clog2(XLEN/8)-1:0] addr,
   input  logic [2:0]                func3,
   input  logic [XLEN-1:0]           data,
   output logic [XLEN/8-1:0]         wstrb,
   output logic [XLEN-1:0]           wdata,
   output logic                      misalign,
   output logic                      illegal
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   logic [NB-1:0]   base;
   logic [XLEN-1:0] dmask;
   logic [OFFW-1:0] low_mask;

   always_comb begin
      base = NB'(size_mask(func3));
      for (int i = 0; i < NB; i++) dmask[8*i +: 8] = {8{base[i]}};
      wstrb = base << addr;
      wdata = (data & dmask) << {addr, 3'b000};
      case (func3[1:0])
         2'd0:    low_mask = '0;
         2'd1:    low_mask = OFFW'(1);
         2'd2:    low_mask = OFFW'(3);
         default: low_mask = OFFW'(7);
      endcase
      misalign = |(addr & low_mask);
      illegal  = func3[2] || (func3 == F3_SD && XLEN == 32);
   end
endmodule

// File: rtl/mem_store_buffer.sv
// Buffered MEM-stage store path: aligns stores, queues them in a DEPTH-entry
// FIFO drained to dmem over valid/ready, and flags load/store word overlaps.
module mem_store_buffer
   import mem_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int MEM_ADDR_W = 8,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic [63:0]           st_addr,
   input  logic [2:0]            st_func3,
   input  logic [XLEN-1:0]       st_data,
   output logic                  st_misalign,
   output logic                  st_illegal,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [XLEN/8-1:0]     mem_wstrb,
   output logic [XLEN-1:0]       mem_wdata,
   input  logic [63:0]           ld_addr,
   output logic                  ld_hazard,
   output logic                  empty
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            misalign_q, misalign_d, illegal_q, illegal_d;

   logic [NB-1:0]   al_wstrb;
   logic [XLEN-1:0] al_wdata;
   logic            al_mis, al_ill;
   logic            take, push, pop;
   entry_t          new_ent, head;

   store_align #(.XLEN(XLEN)) u_align (
      .addr     (st_addr[OFFW-1:0]),
      .func3    (st_func3),
      .data     (st_data),
      .wstrb    (al_wstrb),
      .wdata    (al_wdata),
      .misalign (al_mis),
      .illegal  (al_ill)
   );

   assign head        = mem_q[rd_ptr_q];
   assign st_ready    = (count_q != CW'(DEPTH));
   assign empty       = (count_q == '0);
   assign mem_valid   = vld_q[rd_ptr_q];
   assign mem_addr    = MEM_ADDR_W'(head.addr);
   assign mem_wstrb   = NB'(head.wstrb);
   assign mem_wdata   = XLEN'(head.wdata);
   assign st_misalign = misalign_q;
   assign st_illegal  = illegal_q;

   always_comb begin
      take = st_valid && st_ready;
      push = take && !al_ill && !al_mis;
      pop  = mem_valid && mem_ready;

      new_ent       = '0;
      new_ent.addr  = ADDR_MAX'(MEM_ADDR_W'(st_addr) & ~MEM_ADDR_W'(NB - 1));
      new_ent.wstrb = (XLEN_MAX/8)'(al_wstrb);
      new_ent.wdata = XLEN_MAX'(al_wdata);

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);

      // Clear before set: a push can only land on the popped slot when the FIFO is full, which blocks the push.
      vld_d = vld_q;
      if (pop)  vld_d[rd_ptr_q] = 1'b0;
      if (push) vld_d[wr_ptr_q] = 1'b1;

      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = new_ent;

      illegal_d  = take && al_ill;
      misalign_d = take && al_mis && !al_ill;
   end

   always_comb begin
      ld_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (vld_q[i] && ((MEM_ADDR_W'(mem_q[i].addr) >> OFFW) == (MEM_ADDR_W'(ld_addr) >> OFFW)))
            ld_hazard = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         vld_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         misalign_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         vld_q      <= vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
         illegal_q  <= illegal_d;
      end
   end
endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer (XLEN=64, MEM_ADDR_W=8, DEPTH=4):
// directed scenarios plus a randomized run against a queue-based store model.
module tb_mem_store_buffer;
   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid, st_ready;
   logic [63:0] st_addr;
   logic [2:0]  st_func3;
   logic [63:0] st_data;
   logic        st_misalign, st_illegal;
   logic        mem_valid, mem_ready;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wstrb;
   logic [63:0] mem_wdata;
   logic [63:0] ld_addr;
   logic        ld_hazard, empty;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_store_buffer #(.XLEN(64), .MEM_ADDR_W(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_func3(st_func3), .st_data(st_data),
      .st_misalign(st_misalign), .st_illegal(st_illegal),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .ld_addr(ld_addr), .ld_hazard(ld_hazard), .empty(empty)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_st(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] d);
      st_valid = 1'b1;
      st_addr  = a;
      st_func3 = f3;
      st_data  = d;
   endtask

   // Expected store effect from the ISA rules, with plain integer arithmetic.
   function automatic void ref_store(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] d,
                                     output logic ill, output logic mis, output logic [7:0] ea,
                                     output logic [7:0] strb, output logic [63:0] wd);
      int sz;
      int off;
      logic [63:0] a8;
      sz   = 1 << f3[1:0];
      off  = int'(a % 8);
      a8   = a % 256;
      ill  = f3[2];
      mis  = !ill && ((off % sz) != 0);
      ea   = 8'((a8 / 8) * 8);
      strb = 8'(((1 << sz) - 1) << off);
      wd   = (sz == 8) ? d : (d & ((64'd1 << (8 * sz)) - 64'd1));
      wd   = wd << (8 * off);
   endfunction

   task automatic test_reset;
      rst = 1'b1; st_valid = 0; st_addr = '0; st_func3 = '0; st_data = '0;
      mem_ready = 0; ld_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (st_ready !== 1'b1) $display("FAIL rst_st_ready: got %b exp 1", st_ready); else n_pass++;
      n_chk++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b exp 0", mem_valid); else n_pass++;
      n_chk++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b exp 1", empty); else n_pass++;
      n_chk++; if ({st_misalign, st_illegal, ld_hazard} !== 3'b000)
         $display("FAIL rst_flags: got %b exp 000", {st_misalign, st_illegal, ld_hazard}); else n_pass++;
      n_chk++; if ({mem_addr, mem_wstrb, mem_wdata} !== 80'd0)
         $display("FAIL rst_mem_bus: got %h exp 0", {mem_addr, mem_wstrb, mem_wdata}); else n_pass++;
      #2 rst = 1'b0;
      tick;
      n_chk++; if (empty !== 1'b1 || st_ready !== 1'b1) $display("FAIL rst_release: empty %b ready %b exp 1 1", empty, st_ready); else n_pass++;
   endtask

   task automatic test_sb_align;
      mem_ready = 1'b1;
      drive_st(64'h13, 3'b000, 64'hAB);
      tick;
      st_valid = 1'b0;
      n_chk++; if (mem_valid !== 1'b1) $display("FAIL sb_valid: got %b exp 1", mem_valid); else n_pass++;
      n_chk++; if (mem_addr !== 8'h10) $display("FAIL sb_addr: got %h exp 10", mem_addr); else n_pass++;
      n_chk++; if (mem_wstrb !== 8'h08) $display("FAIL sb_wstrb: got %h exp 08", mem_wstrb); else n_pass++;
      n_chk++; if (mem_wdata !== 64'h00000000AB000000) $display("FAIL sb_wdata: got %h exp 00000000ab000000", mem_wdata); else n_pass++;
      tick;
      n_chk++; if (mem_valid !== 1'b0 || empty !== 1'b1) $display("FAIL sb_drained: valid %b empty %b exp 0 1", mem_valid, empty); else n_pass++;
      mem_ready = 1'b0;
   endtask

   task automatic test_misalign_illegal;
      drive_st(64'h05, 3'b001, 64'h1234);
      tick;
      st_valid = 1'b0;
      n_chk++; if ({st_misalign, st_illegal} !== 2'b10) $display("FAIL sh_mis_flags: got %b exp 10", {st_misalign, st_illegal}); else n_pass++;
      n_chk++; if (mem_valid !== 1'b0 || empty !== 1'b1) $display("FAIL sh_mis_noenq: valid %b empty %b exp 0 1", mem_valid, empty); else n_pass++;
      tick;
      n_chk++; if (st_misalign !== 1'b0) $display("FAIL sh_mis_pulse: got %b exp 0", st_misalign); else n_pass++;
      drive_st(64'h08, 3'b100, 64'h55);
      tick;
      st_valid = 1'b0;
      n_chk++; if ({st_misalign, st_illegal} !== 2'b01) $display("FAIL f3_ill_flags: got %b exp 01", {st_misalign, st_illegal}); else n_pass++;
      n_chk++; if (empty !== 1'b1) $display("FAIL f3_ill_noenq: empty %b exp 1", empty); else n_pass++;
      tick;
      n_chk++; if (st_illegal !== 1'b0) $display("FAIL f3_ill_pulse: got %b exp 0", st_illegal); else n_pass++;
      drive_st(64'h03, 3'b111, 64'h1);
      tick;
      st_valid = 1'b0;
      n_chk++; if ({st_misalign, st_illegal} !== 2'b01) $display("FAIL both_prio: got %b exp 01", {st_misalign, st_illegal}); else n_pass++;
      tick;
   endtask

   task automatic test_full_drain;
      logic [63:0] d [4];
      mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         d[k] = {$urandom, $urandom};
         n_chk++; if (st_ready !== 1'b1) $display("FAIL fill_ready%0d: got %b exp 1", k, st_ready); else n_pass++;
         drive_st(64'(8 * k), 3'b011, d[k]);
         tick;
      end
      drive_st(64'h20, 3'b011, 64'hDEAD);
      n_chk++; if (st_ready !== 1'b0) $display("FAIL full_ready: got %b exp 0", st_ready); else n_pass++;
      tick;
      n_chk++; if (st_ready !== 1'b0 || mem_addr !== 8'h00) $display("FAIL full_stall: ready %b addr %h exp 0 00", st_ready, mem_addr); else n_pass++;
      st_valid  = 1'b0;
      mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_chk++; if (mem_valid !== 1'b1 || mem_addr !== 8'(8 * k) || mem_wstrb !== 8'hFF || mem_wdata !== d[k])
            $display("FAIL drain%0d: v %b a %h s %h d %h exp 1 %h ff %h", k, mem_valid, mem_addr, mem_wstrb, mem_wdata, 8'(8 * k), d[k]);
         else n_pass++;
         n_chk++; if (st_ready !== (k != 0)) $display("FAIL drain_ready%0d: got %b exp %b", k, st_ready, k != 0); else n_pass++;
         tick;
      end
      n_chk++; if (empty !== 1'b1 || mem_valid !== 1'b0) $display("FAIL drain_empty: empty %b valid %b exp 1 0", empty, mem_valid); else n_pass++;
      mem_ready = 1'b0;
   endtask

   task automatic test_hazard;
      mem_ready = 1'b0;
      drive_st(64'h24, 3'b010, 64'hFFFF_FFFF_1234_5678);
      tick;
      st_valid = 1'b0;
      n_chk++; if (mem_wstrb !== 8'hF0 || mem_wdata !== 64'h12345678_00000000)
         $display("FAIL sw_lane: s %h d %h exp f0 1234567800000000", mem_wstrb, mem_wdata); else n_pass++;
      ld_addr = 64'h20; #1;
      n_chk++; if (ld_hazard !== 1'b1) $display("FAIL hz_hit: got %b exp 1", ld_hazard); else n_pass++;
      ld_addr = 64'h28; #1;
      n_chk++; if (ld_hazard !== 1'b0) $display("FAIL hz_miss: got %b exp 0", ld_hazard); else n_pass++;
      ld_addr = 64'hABCD_0000_0000_0127; #1;
      n_chk++; if (ld_hazard !== 1'b1) $display("FAIL hz_highbits: got %b exp 1", ld_hazard); else n_pass++;
      mem_ready = 1'b1;
      tick;
      n_chk++; if (ld_hazard !== 1'b0) $display("FAIL hz_after_drain: got %b exp 0", ld_hazard); else n_pass++;
      mem_ready = 1'b0; ld_addr = '0;
   endtask

   task automatic test_back_to_back;
      logic [7:0]  qa [$];
      logic [63:0] qd [$];
      logic [63:0] dv;
      mem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         dv = {$urandom, $urandom};
         drive_st(64'(8 * k + 8'h40), 3'b011, dv);
         qa.push_back(8'(8 * k + 8'h40)); qd.push_back(dv);
         tick;
      end
      for (int k = 0; k < 10; k++) begin
         n_chk++; if (mem_valid !== 1'b1 || st_ready !== 1'b1 || mem_addr !== qa[0] || mem_wdata !== qd[0])
            $display("FAIL b2b%0d: v %b r %b a %h d %h exp 1 1 %h %h", k, mem_valid, st_ready, mem_addr, mem_wdata, qa[0], qd[0]);
         else n_pass++;
         dv = {$urandom, $urandom};
         drive_st(64'(8 * (k + 2) + 8'h40), 3'b011, dv);
         mem_ready = 1'b1;
         qa.push_back(8'(8 * (k + 2) + 8'h40)); qd.push_back(dv);
         tick;
         void'(qa.pop_front()); void'(qd.pop_front());
      end
      st_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_chk++; if (mem_valid !== 1'b1 || mem_addr !== qa[0] || mem_wdata !== qd[0])
            $display("FAIL b2b_tail%0d: v %b a %h d %h exp 1 %h %h", k, mem_valid, mem_addr, mem_wdata, qa[0], qd[0]);
         else n_pass++;
         tick;
         void'(qa.pop_front()); void'(qd.pop_front());
      end
      n_chk++; if (empty !== 1'b1) $display("FAIL b2b_count: empty %b exp 1", empty); else n_pass++;
      mem_ready = 1'b0;
   endtask

   task automatic test_async_reset;
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_st(64'(8'h80 + 8 * k), 3'b011, 64'(k + 1));
         tick;
      end
      st_valid = 1'b0;
      mem_ready = 1'b1;
      #3 rst = 1'b1;
      #1;
      n_chk++; if (mem_valid !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1)
         $display("FAIL arst_now: v %b e %b r %b exp 0 1 1", mem_valid, empty, st_ready); else n_pass++;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick;
         n_chk++; if (mem_valid !== 1'b0 || empty !== 1'b1) $display("FAIL arst_after%0d: v %b e %b exp 0 1", k, mem_valid, empty); else n_pass++;
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_random;
      logic [7:0]  qa [$];
      logic [7:0]  qs [$];
      logic [63:0] qd [$];
      logic exp_mis, exp_ill, ill, mis, hz, taken;
      logic [7:0]  ea, es;
      logic [63:0] ed;
      exp_mis = 1'b0; exp_ill = 1'b0;
      for (int c = 0; c < 400; c++) begin
         n_chk++; if (st_ready !== (qa.size() < 4) || mem_valid !== (qa.size() > 0) || empty !== (qa.size() == 0))
            $display("FAIL rnd_ctl%0d: r %b v %b e %b for %0d queued", c, st_ready, mem_valid, empty, qa.size());
         else n_pass++;
         n_chk++; if (st_misalign !== exp_mis || st_illegal !== exp_ill)
            $display("FAIL rnd_flags%0d: got %b%b exp %b%b", c, st_misalign, st_illegal, exp_mis, exp_ill);
         else n_pass++;
         if (qa.size() > 0) begin
            n_chk++; if (mem_addr !== qa[0] || mem_wstrb !== qs[0] || mem_wdata !== qd[0])
               $display("FAIL rnd_head%0d: a %h s %h d %h exp %h %h %h", c, mem_addr, mem_wstrb, mem_wdata, qa[0], qs[0], qd[0]);
            else n_pass++;
         end
         st_valid  = ($urandom_range(0, 3) != 0);
         st_addr   = {32'($urandom), 24'($urandom), 8'($urandom_range(0, 63))};
         st_func3  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         st_data   = {$urandom, $urandom};
         mem_ready = ($urandom_range(0, 2) != 0);
         ld_addr   = {32'($urandom), 24'($urandom), 8'($urandom_range(0, 63))};
         #1;
         hz = 1'b0;
         foreach (qa[i]) if ((qa[i] / 8) == (ld_addr[7:0] / 8)) hz = 1'b1;
         n_chk++; if (ld_hazard !== hz) $display("FAIL rnd_hz%0d: got %b exp %b", c, ld_hazard, hz); else n_pass++;
         ref_store(st_addr, st_func3, st_data, ill, mis, ea, es, ed);
         taken   = st_valid && (qa.size() < 4);
         exp_ill = taken && ill;
         exp_mis = taken && mis;
         if (mem_ready && qa.size() > 0) begin
            void'(qa.pop_front()); void'(qs.pop_front()); void'(qd.pop_front());
         end
         if (taken && !ill && !mis) begin
            qa.push_back(ea); qs.push_back(es); qd.push_back(ed);
         end
         @(posedge clk);
         #1;
      end
      st_valid = 1'b0; mem_ready = 1'b1;
      repeat (6) tick;
      n_chk++; if (empty !== 1'b1) $display("FAIL rnd_final_empty: got %b exp 1", empty); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_sb_align;
      test_misalign_illegal;
      test_full_drain;
      test_hazard;
      test_back_to_back;
      test_async_reset;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Parametrised, buffered successor to the combinational store path between the MEM stage and data memory.
- Takes RISC-V stores (SB/SH/SW/SD), lane-aligns data and byte strobes to the XLEN-wide memory word, and rejects misaligned or illegal stores.
- Queues accepted stores in a DEPTH-entry FIFO and drains them to dmem over a valid/ready handshake.
- Flags any queued store that overlaps a pending load address so the pipeline can stall.

Parameters:
- XLEN, 64, data width in bits; power of two, 32 or 64.
- MEM_ADDR_W, 8, byte-address width presented to dmem.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request from the MEM stage.
- st_ready  out  1  buffer can accept a request this cycle.
- st_addr  in  64  store byte address.
- st_func3  in  3  store width: 000 SB, 001 SH, 010 SW, 011 SD.
- st_data  in  XLEN  store data, right-justified.
- st_misalign  out  1  registered one-cycle pulse: last request was misaligned.
- st_illegal  out  1  registered one-cycle pulse: last request had bad func3 (or SD with XLEN=32).
- mem_valid  out  1  FIFO head is valid.
- mem_ready  in  1  dmem accepts the head entry.
- mem_addr  out  MEM_ADDR_W  word-aligned byte address; low log2(XLEN/8) bits are zero.
- mem_wstrb  out  XLEN/8  byte write enables.
- mem_wdata  out  XLEN  lane-shifted write data.
- ld_addr  in  64  address of the load currently in MEM.
- ld_hazard  out  1  combinational: some valid entry matches ld_addr word.
- empty  out  1  FIFO empty; used by fence.

Behaviour:
- Reset: pointers and count go to 0; entries are invalidated. Outputs: st_ready=1, mem_valid=0, empty=1, st_misalign=0, st_illegal=0, ld_hazard=0. mem_addr, mem_wstrb and mem_wdata are 0.
- Reset mid-operation: every queued store is discarded. No partial drain occurs.
- Lane offset: off = st_addr[log2(XLEN/8)-1:0].
- Base strobe by size: SB=1, SH=3, SW=F, SD=FF.
- wstrb = base << off.
- wdata = (st_data masked to size) << (8*off); bits above the store size are zeroed before the shift.
- Misaligned: off not a multiple of the size (SH with off[0]; SW with off[1:0]≠0; SD with off≠0).
- Illegal: func3 is 1xx, or SD when XLEN=32.
- Handshake: a request is taken when st_valid && st_ready.
  - Legal and aligned: enqueue.
  - Misaligned or illegal: consumed but not enqueued; the matching flag pulses high the next cycle for exactly one cycle.
  - If both conditions hold, only st_illegal is raised.
- st_ready = !full. No pass-through when full, even if a dequeue happens in the same cycle.
- Dequeue on mem_valid && mem_ready. mem_* outputs come directly from the head entry registers, with zero added latency. A store accepted in cycle N first appears on mem_valid in cycle N+1.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. full = (count==DEPTH).
- Empty FIFO: mem_valid=0; mem_ready is ignored.
- mem_* must hold stable while mem_valid && !mem_ready.
- ld_hazard: OR over valid entries of (entry word address == ld_addr[MEM_ADDR_W-1:log2(XLEN/8)]). Entries being dequeued in the same cycle still count.
- Address bits above MEM_ADDR_W are ignored.

Decomposition:
- Shared package mem_pkg holds:
  - func3 constants F3_SB, F3_SH, F3_SW, F3_SD.
  - Function size_mask(func3) returning the base strobe.
  - Entry struct {addr, wstrb, wdata}.
- One sub-module, store_align: purely combinational. Inputs: addr, func3, data. Outputs: wstrb, wdata, misalign, illegal.
- FIFO storage and control stay in mem_store_buffer.

Test Plan:
- SB addr 0x13, data 0xAB, XLEN=64, mem_ready=1 → next cycle: mem_valid=1, mem_addr=0x10, wstrb=0x08, wdata=0x00000000AB000000.
- SH addr 0x05 → st_misalign pulses 1 cycle later, mem_valid stays 0, empty stays 1. Then func3=100 at addr 0x08 → st_illegal pulses, nothing enqueued.
- mem_ready=0, DEPTH=4: four SDs at 0x00, 0x08, 0x10, 0x18 → st_ready=0 after the 4th; a 5th request is stalled. Raise mem_ready → entries drain in order 0x00→0x18, wstrb=0xFF each, and st_ready returns the cycle after the first dequeue.
- Queue SW at 0x24 with mem_ready=0; ld_addr=0x20 → ld_hazard=1. ld_addr=0x28 → ld_hazard=0.
- FIFO with 2 entries: enqueue and dequeue every cycle for 10 cycles → count stays 2, order preserved across pointer wrap, no data loss.
- Assert rst asynchronously mid-drain with 3 queued → immediately mem_valid=0, empty=1, st_ready=1. No queued store reappears after reset is released.
